lct_quality_pipe: RTL and testbench

- Pipelined, multi-channel successor to the combinational LCT quality encoder.
- Computes a 4-bit TMB quality for NCH ALCT/CLCT match candidates per bunch crossing.
- Registers the result with a valid flag and picks the best channel.
- Keeps per-channel, per-quality saturating occupancy counters for VME readout; sits between the ALCT/CLCT matcher and the MPC frame builder.

---
 rtl/lct_quality_pipe_if.sv | 23 ++
 rtl/lct_quality_pipe.sv | 132 +++++++++++++
 tb/tb_lct_quality_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lct_quality_pipe_if.sv
// lct_quality_pipe_if: candidate bus into the LCT quality pipe and its registered result bus.
//   master -> slave : vld_in, acc, a, c, a4, c4, cpat [NCH]; pat [NCH*PATBITS] (channel k at k*PATBITS)
//   slave -> master : q_out [NCH*4], vld_out [NCH], best_vld, best_ch [3], best_q [4]
interface lct_quality_pipe_if #(
    parameter int NCH     = 2,
    parameter int PATBITS = 4
);
    logic [NCH-1:0]         vld_in, acc, a, c, a4, c4, cpat;
    logic [NCH*PATBITS-1:0] pat;
    logic [NCH*4-1:0]       q_out;
    logic [NCH-1:0]         vld_out;
    logic                   best_vld;
    logic [2:0]             best_ch;
    logic [3:0]             best_q;
    modport master (
        output vld_in, acc, a, c, a4, c4, cpat, pat,
        input  q_out, vld_out, best_vld, best_ch, best_q
    );
    modport slave (
        input  vld_in, acc, a, c, a4, c4, cpat, pat,
        output q_out, vld_out, best_vld, best_ch, best_q
    );
endinterface

// File: rtl/lct_quality_pipe.sv
// lct_quality_pipe: two-stage pipelined multi-channel TMB quality encoder with best-channel pick
// and per-channel/per-quality saturating occupancy counters.
//   clock, reset_n (async, active-low)
//   bus        : candidate inputs / registered quality results (lct_quality_pipe_if.slave)
//   ext_mode   : 0 legacy table, 1 extended table (travels with its data through stage 1)
//   cnt_clear  : synchronous clear of all counters, wins over a same-edge increment
//   rd_ch/rd_q : counter select; rd_cnt is the registered pre-update value, 0 for rd_ch >= NCH
module lct_quality_pipe #(
    parameter int NCH     = 2,
    parameter int CNTBITS = 16,
    parameter int PATBITS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    lct_quality_pipe_if.slave  bus,
    input  logic               ext_mode,
    input  logic               cnt_clear,
    input  logic [2:0]         rd_ch,
    input  logic [3:0]         rd_q,
    output logic [CNTBITS-1:0] rd_cnt
);
    logic [NCH-1:0]         vld_s1_q, acc_s1_q, a_s1_q, c_s1_q, a4_s1_q, c4_s1_q, cpat_s1_q;
    logic [NCH*PATBITS-1:0] pat_s1_q;
    logic                   ext_s1_q;
    logic [3:0]             qk [NCH];
    logic [NCH*4-1:0]       q_d, q_q;
    logic [NCH-1:0]         vld_out_q;
    logic                   best_vld_d, best_vld_q;
    logic [2:0]             best_ch_d, best_ch_q;
    logic [3:0]             best_q_d, best_q_q;
    logic [CNTBITS-1:0]     cnt_d [NCH][16];
    logic [CNTBITS-1:0]     cnt_q [NCH][16];
    logic [CNTBITS-1:0]     rd_cnt_d, rd_cnt_q;

    function automatic logic [3:0] qual(input logic acc_i, a_i, c_i, a4_i, c4_i, cpat_i, ext_i,
                                        input int p);
        logic hq;
        hq = !acc_i && a4_i && c4_i;
        return (hq && p == 10)                                  ? 4'd15 :
               (hq && (p == 8 || p == 9))                       ? 4'd14 :
               (hq && (p == 6 || p == 7))                       ? 4'd13 :
               (hq && (p == 4 || p == 5))                       ? 4'd12 :
               (hq && (p == 2 || p == 3))                       ? 4'd11 :
               (ext_i && hq && p >= 11 && p <= 13)              ? 4'd10 :
               (ext_i && hq && p >= 14 && p <= 15)              ? 4'd9  :
               (acc_i && a4_i && c4_i && cpat_i)                ? 4'd8  :
               (a_i && !a4_i && c4_i && cpat_i)                 ? 4'd7  :
               (a4_i && c_i && !c4_i && cpat_i)                 ? 4'd6  :
               (a_i && !a4_i && c_i && !c4_i && cpat_i)         ? 4'd5  :
               (ext_i && a_i && c_i && !cpat_i && p >= 11)      ? 4'd4  :
               (a_i && c_i && p == 1)                           ? 4'd3  :
               (!a_i && c_i)                                    ? 4'd2  :
               (a_i && !c_i)                                    ? 4'd1  : 4'd0;
    endfunction

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            qk[k] = vld_s1_q[k] ? qual(acc_s1_q[k], a_s1_q[k], c_s1_q[k], a4_s1_q[k], c4_s1_q[k],
                                       cpat_s1_q[k], ext_s1_q,
                                       int'(pat_s1_q[k*PATBITS +: PATBITS])) : 4'd0;
        end
    end

    always_comb begin
        q_d        = '0;
        best_vld_d = 1'b0;
        best_ch_d  = '0;
        best_q_d   = '0;
        cnt_d      = cnt_q;
        rd_cnt_d   = '0;
        for (int k = 0; k < NCH; k++) begin
            q_d[k*4 +: 4] = qk[k];
            // strict compare keeps the lowest channel index on a quality tie
            if (vld_s1_q[k] && (!best_vld_d || qk[k] > best_q_d)) begin
                best_vld_d = 1'b1;
                best_ch_d  = 3'(k);
                best_q_d   = qk[k];
            end
            if (cnt_clear)
                cnt_d[k] = '{default: '0};
            else if (vld_s1_q[k] && cnt_q[k][qk[k]] != '1)
                cnt_d[k][qk[k]] = cnt_q[k][qk[k]] + 1'b1;
            if (int'(rd_ch) == k)
                rd_cnt_d = cnt_q[k][rd_q];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_s1_q   <= '0;
            acc_s1_q   <= '0;
            a_s1_q     <= '0;
            c_s1_q     <= '0;
            a4_s1_q    <= '0;
            c4_s1_q    <= '0;
            cpat_s1_q  <= '0;
            pat_s1_q   <= '0;
            ext_s1_q   <= 1'b0;
            q_q        <= '0;
            vld_out_q  <= '0;
            best_vld_q <= 1'b0;
            best_ch_q  <= '0;
            best_q_q   <= '0;
            cnt_q      <= '{default: '0};
            rd_cnt_q   <= '0;
        end else begin
            vld_s1_q   <= bus.vld_in;
            acc_s1_q   <= bus.acc;
            a_s1_q     <= bus.a;
            c_s1_q     <= bus.c;
            a4_s1_q    <= bus.a4;
            c4_s1_q    <= bus.c4;
            cpat_s1_q  <= bus.cpat;
            pat_s1_q   <= bus.pat;
            ext_s1_q   <= ext_mode;
            q_q        <= q_d;
            vld_out_q  <= vld_s1_q;
            best_vld_q <= best_vld_d;
            best_ch_q  <= best_ch_d;
            best_q_q   <= best_q_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    assign bus.q_out    = q_q;
    assign bus.vld_out  = vld_out_q;
    assign bus.best_vld = best_vld_q;
    assign bus.best_ch  = best_ch_q;
    assign bus.best_q   = best_q_q;
    assign rd_cnt       = rd_cnt_q;
endmodule

// File: tb/tb_lct_quality_pipe.sv
// tb_lct_quality_pipe: directed and random stimulus against a behavioural model of the quality pipe.
module tb_lct_quality_pipe;
    localparam int NCH = 2;
    localparam int CB  = 4;
    localparam int PB  = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ext_mode = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [2:0]    rd_ch = '0;
    logic [3:0]    rd_q = '0;
    logic [CB-1:0] rd_cnt;

    always #5 clock = ~clock;

    lct_quality_pipe_if #(.NCH(NCH), .PATBITS(PB)) bus ();

    lct_quality_pipe #(.NCH(NCH), .CNTBITS(CB), .PATBITS(PB)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .ext_mode  (ext_mode),
        .cnt_clear (cnt_clear),
        .rd_ch     (rd_ch),
        .rd_q      (rd_q),
        .rd_cnt    (rd_cnt)
    );

    typedef struct packed {
        logic [NCH-1:0]    vld, acc, a, c, a4, c4, cpat;
        logic [NCH*PB-1:0] pat;
        logic              ext;
    } rec_t;

    rec_t          prev;
    int unsigned   mcnt [NCH][16];
    logic [NCH*4-1:0] eq;
    logic [NCH-1:0]   ev;
    logic          ebv;
    logic [2:0]    ebc;
    logic [3:0]    ebq;
    logic [CB-1:0] erd;
    int            tests = 0;
    int            fails = 0;

    // Quality from the table rules; the high-quality rows collapse to 10 + P/2 for P in 2..10.
    function automatic int mq(bit acc, bit a, bit c, bit a4, bit c4, bit cpat, bit ext, int p);
        bit hq;
        hq = !acc && a4 && c4;
        if (hq && p >= 2 && p <= 10) return 10 + p / 2;
        if (hq && ext && p >= 11) return (p <= 13) ? 10 : 9;
        if (acc && a4 && c4 && cpat) return 8;
        if (cpat && a && !a4 && c4) return 7;
        if (cpat && a4 && c && !c4) return 6;
        if (cpat && a && !a4 && c && !c4) return 5;
        if (ext && a && c && !cpat && p >= 11) return 4;
        if (a && c && p == 1) return 3;
        if (!a && c) return 2;
        if (a && !c) return 1;
        return 0;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("q_out", 32'(bus.q_out), 32'(eq));
        chk("vld_out", 32'(bus.vld_out), 32'(ev));
        chk("best_vld", 32'(bus.best_vld), 32'(ebv));
        chk("best_ch", 32'(bus.best_ch), 32'(ebc));
        chk("best_q", 32'(bus.best_q), 32'(ebq));
        chk("rd_cnt", 32'(rd_cnt), 32'(erd));
    endtask

    task automatic model_clear();
        prev = '0;
        eq = '0; ev = '0; ebv = 1'b0; ebc = '0; ebq = '0; erd = '0;
        for (int k = 0; k < NCH; k++)
            for (int q = 0; q < 16; q++) mcnt[k][q] = 0;
    endtask

    // One clock edge: advance the model with what was on the inputs, then compare.
    task automatic tick();
        rec_t cur;
        int qs [NCH];
        int mx;
        bit found;
        cur = '{vld: bus.vld_in, acc: bus.acc, a: bus.a, c: bus.c, a4: bus.a4, c4: bus.c4,
                cpat: bus.cpat, pat: bus.pat, ext: ext_mode};
        @(posedge clock);
        if (reset_n) begin
            erd = '0;
            if (int'(rd_ch) < NCH) erd = CB'(mcnt[rd_ch][rd_q]);
            mx = 0;
            for (int k = 0; k < NCH; k++) begin
                qs[k] = prev.vld[k] ? mq(prev.acc[k], prev.a[k], prev.c[k], prev.a4[k], prev.c4[k],
                                         prev.cpat[k], prev.ext, int'(prev.pat[k*PB +: PB])) : 0;
                eq[k*4 +: 4] = 4'(qs[k]);
                if (prev.vld[k] && qs[k] > mx) mx = qs[k];
            end
            found = 0;
            ebc = '0;
            for (int k = 0; k < NCH; k++)
                if (!found && prev.vld[k] && qs[k] == mx) begin
                    ebc = 3'(k);
                    found = 1;
                end
            ev  = prev.vld;
            ebv = |prev.vld;
            ebq = ebv ? 4'(mx) : 4'd0;
            for (int k = 0; k < NCH; k++) begin
                if (cnt_clear) for (int q = 0; q < 16; q++) mcnt[k][q] = 0;
                else if (prev.vld[k] && mcnt[k][qs[k]] < (1 << CB) - 1) mcnt[k][qs[k]]++;
            end
            prev = cur;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic set_ch(int k, bit v, bit acc, bit a, bit c, bit a4, bit c4, bit cpat, int p);
        bus.vld_in[k] = v; bus.acc[k] = acc; bus.a[k] = a; bus.c[k] = c;
        bus.a4[k] = a4; bus.c4[k] = c4; bus.cpat[k] = cpat;
        bus.pat[k*PB +: PB] = PB'(p);
    endtask

    task automatic idle();
        for (int k = 0; k < NCH; k++) set_ch(k, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        model_clear();
        chk("pin mq p10", 32'(mq(0, 1, 1, 1, 1, 1, 0, 10)), 15);
        chk("pin mq p3", 32'(mq(0, 1, 1, 1, 1, 1, 0, 3)), 11);
        chk("pin mq ext p14", 32'(mq(0, 1, 1, 1, 1, 1, 1, 14)), 9);
        chk("pin mq legacy p12", 32'(mq(0, 1, 1, 1, 1, 1, 0, 12)), 0);
        do_reset();

        // single HQ candidate on ch0, pattern 10
        set_ch(0, 1, 0, 1, 1, 1, 1, 1, 10);
        tick();
        idle();
        tick();
        chk("t1 q0", 32'(bus.q_out[3:0]), 15);
        chk("t1 vld", 32'(bus.vld_out), 1);
        chk("t1 best_ch", 32'(bus.best_ch), 0);
        chk("t1 best_q", 32'(bus.best_q), 15);
        rd_ch = 0; rd_q = 15;
        tick();
        chk("t1 cnt", 32'(rd_cnt), 1);

        // reserved patterns: 0 in legacy mode, 10 in extended mode with tie to ch0
        set_ch(0, 1, 0, 1, 1, 1, 1, 1, 12);
        set_ch(1, 1, 0, 1, 1, 1, 1, 1, 12);
        tick();
        ext_mode = 1'b1;
        tick();
        chk("t2 legacy q", 32'(bus.q_out), 0);
        chk("t2 legacy best_vld", 32'(bus.best_vld), 1);
        chk("t2 legacy best_q", 32'(bus.best_q), 0);
        idle();
        tick();
        chk("t2 ext q", 32'(bus.q_out), 32'h0000_00aa);
        chk("t2 ext best_ch", 32'(bus.best_ch), 0);
        chk("t2 ext best_q", 32'(bus.best_q), 10);

        // ext_mode toggled every clock with constant P=14 HQ input
        set_ch(0, 1, 0, 1, 1, 1, 1, 1, 14);
        for (int i = 0; i < 6; i++) begin
            ext_mode = i[0];
            tick();
            if (i == 4) chk("t3 ext q", 32'(bus.q_out[3:0]), 9);
            if (i == 5) chk("t3 legacy q", 32'(bus.q_out[3:0]), 0);
        end
        ext_mode = 1'b0;
        idle();

        // 20 q=7 events on ch1 saturate the 4-bit counter, then clear drops the last one
        set_ch(1, 1, 0, 1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        idle();
        cnt_clear = 1'b1; rd_ch = 1; rd_q = 7;
        tick();
        chk("t4 saturated", 32'(rd_cnt), 15);
        cnt_clear = 1'b0;
        tick();
        chk("t4 cleared", 32'(rd_cnt), 0);

        // ch0 ALCT only, ch1 CLCT only; out-of-range readout channel
        set_ch(0, 1, 0, 1, 0, 0, 0, 0, 0);
        set_ch(1, 1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        chk("t5 q", 32'(bus.q_out), 32'h21);
        chk("t5 best_ch", 32'(bus.best_ch), 1);
        chk("t5 best_q", 32'(bus.best_q), 2);
        rd_ch = 0; rd_q = 1;
        tick();
        chk("t5 cnt ch0 q1", 32'(rd_cnt), 1);
        rd_ch = 5;
        tick();
        chk("t5 rd_ch oob", 32'(rd_cnt), 0);

        // reset between a candidate and its result
        set_ch(0, 1, 0, 1, 1, 1, 1, 1, 10);
        tick();
        do_reset();
        idle();
        rd_ch = 0; rd_q = 15;
        tick();
        chk("t6 vld", 32'(bus.vld_out), 0);
        tick();
        chk("t6 vld2", 32'(bus.vld_out), 0);
        chk("t6 cnt", 32'(rd_cnt), 0);

        // random traffic with occasional clears and a mid-run reset
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH; k++)
                set_ch(k, ($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom % 2,
                       ($urandom % 4) != 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 16);
            ext_mode  = $urandom % 2;
            cnt_clear = ($urandom % 64) == 0;
            rd_ch     = 3'($urandom % 4);
            rd_q      = 4'($urandom % 16);
            tick();
            if (i == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
